// File: rtl/cop_ise_arb_pkg.sv
// Shared types and constants for the two-requester Ascon/RV64 ISE co-processor front-end.
package cop_ise_arb_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPC_W = 7;

    // RISC-V custom opcode space used by the ISE
    localparam logic [OPC_W-1:0] CUSTOM_0 = 7'h0B;
    localparam logic [OPC_W-1:0] CUSTOM_1 = 7'h2B;
    localparam logic [OPC_W-1:0] CUSTOM_2 = 7'h5B;
    localparam logic [OPC_W-1:0] CUSTOM_3 = 7'h7B;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Issue-register payload: owner tag plus the operands handed to the co-processor
    typedef struct packed {
        req_id_e          owner;
        logic [ILEN-1:0]  insn;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
    } ise_req_t;

    typedef struct packed {
        logic             wr;
        logic [XLEN-1:0]  rd;
    } ise_rsp_t;

endpackage

// File: rtl/cop_rr_arb2.sv
// Two-way round-robin grant; the last accepted requester loses the next tie.
module cop_rr_arb2
    import cop_ise_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0_c,
    output logic grant1_c
);

    req_id_e rr_last;

    // Reset to REQ1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= REQ1;
        end else if (advance && valid0 && grant0_c) begin
            rr_last <= REQ0;
        end else if (advance && valid1 && grant1_c) begin
            rr_last <= REQ1;
        end
    end

    // Grants never look at the requester's own valid
    always_comb begin
        grant0_c = ~valid1 | (rr_last == REQ1);
        grant1_c = ~valid0 | (rr_last == REQ0);
    end

endmodule

// File: rtl/cop_ise_arb.sv
// Two-requester front-end: round-robin issue into a one-entry IR, per-requester response slots.
module cop_ise_arb
    import cop_ise_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             cop_clk,
    input  logic             cop_rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ILEN-1:0]  req0_insn,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_rs2,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ILEN-1:0]  req1_insn,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_rs2,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp0_wr,
    output logic [XLEN-1:0]  rsp0_rd,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp1_wr,
    output logic [XLEN-1:0]  rsp1_rd,

    output logic             ise_valid,
    output logic [ILEN-1:0]  ise_insn,
    output logic [XLEN-1:0]  ise_rs1,
    output logic [XLEN-1:0]  ise_rs2,
    output logic             ise_rdywr,
    input  logic             ise_ready,
    input  logic             ise_wr,
    input  logic [XLEN-1:0]  ise_rd,

    output logic [CNT_W-1:0] perf_stall
);

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic            ir_v;
    ise_req_t        ir_q;
    ise_req_t        ir_d;
    logic [1:0]      slot_free;
    logic [1:0]      rsp_v;
    logic [1:0]      rsp_wr;
    logic [1:0]      rsp_rdy;
    logic [XLEN-1:0] rsp_rd [2];
    logic            retire;
    logic            ir_free;
    logic            grant0;
    logic            grant1;
    logic            acc0;
    logic            acc1;
    logic [CNT_W-1:0] stall_q;

    assign rsp_rdy   = {rsp1_ready, rsp0_ready};
    assign slot_free = ~rsp_v | rsp_rdy;

    // Retirement waits for the owner's slot even when the op is unrecognised
    assign retire    = ir_v & ise_ready & slot_free[ir_q.owner];
    assign ir_free   = ~ir_v | retire;

    u_arb_unused_guard: assert property (@(posedge cop_clk) disable iff (cop_rst) !(acc0 && acc1));

    cop_rr_arb2 u_arb (
        .clk      (cop_clk),
        .rst      (cop_rst),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .advance  (ir_free),
        .grant0_c (grant0),
        .grant1_c (grant1)
    );

    assign req0_ready = ir_free & grant0;
    assign req1_ready = ir_free & grant1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    // Next IR payload: the accepted request, otherwise hold
    always_comb begin
        ir_d = ir_q;
        if (acc0) begin
            ir_d = '{owner: REQ0, insn: req0_insn, rs1: req0_rs1, rs2: req0_rs2};
        end else if (acc1) begin
            ir_d = '{owner: REQ1, insn: req1_insn, rs1: req1_rs1, rs2: req1_rs2};
        end
    end

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            ir_v <= 1'b0;
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
            if (acc0 || acc1) begin
                ir_v <= 1'b1;
            end else if (retire) begin
                ir_v <= 1'b0;
            end
        end
    end

    // One response slot per requester; a refill wins over a same-cycle pop
    for (genvar g = 0; g < 2; g++) begin : g_slot
        logic     v_q;
        ise_rsp_t q;
        logic     fill;
        logic     pop;

        assign fill = retire & (ir_q.owner == ((g == 0) ? REQ0 : REQ1));
        assign pop  = v_q & rsp_rdy[g];

        always_ff @(posedge cop_clk) begin
            if (cop_rst) begin
                v_q <= 1'b0;
                q   <= '0;
            end else if (fill) begin
                v_q <= 1'b1;
                q   <= '{wr: ise_wr, rd: ise_rd};
            end else if (pop) begin
                v_q <= 1'b0;
            end
        end

        assign rsp_v[g]  = v_q;
        assign rsp_wr[g] = q.wr;
        assign rsp_rd[g] = q.rd;
    end

    // Saturating count of cycles the IR is occupied without retiring
    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            stall_q <= '0;
        end else if (ir_v && !retire && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ise_valid  = ir_v;
    assign ise_insn   = ir_q.insn;
    assign ise_rs1    = ir_q.rs1;
    assign ise_rs2    = ir_q.rs2;
    assign ise_rdywr  = slot_free[ir_q.owner];

    assign rsp0_valid = rsp_v[0];
    assign rsp0_wr    = rsp_wr[0];
    assign rsp0_rd    = rsp_rd[0];
    assign rsp1_valid = rsp_v[1];
    assign rsp1_wr    = rsp_wr[1];
    assign rsp1_rd    = rsp_rd[1];
    assign perf_stall = stall_q;

endmodule

// File: doc/cop_ise_arb.md
Name: cop_ise_arb

Overview:
- Two-requester front-end for the Ascon/RV64 ISE co-processor.
- Lets two issue sources share one co-processor instance, for example two hart contexts or a core plus a DMA-style permutation driver.
- Arbitrates requests round-robin and registers the winning request in a one-entry issue register (IR) that drives the co-processor.
- Captures each result into a per-requester response buffer, applying back-pressure through cop_rdywr.

Parameters:
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- cop_clk  in  1  clock; the block uses this single clock.
- cop_rst  in  1  reset; synchronous, active-high.
- req0_valid / req1_valid  in  1  request valid, per requester.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_insn / req1_insn  in  32  instruction word.
- req0_rs1 / req1_rs1  in  64  source operand 1.
- req0_rs2 / req1_rs2  in  64  source operand 2.
- rsp0_valid / rsp1_valid  out  1  response available.
- rsp0_ready / rsp1_ready  in  1  requester consumes the response.
- rsp0_wr / rsp1_wr  out  1  instruction was recognised; rd is valid for writeback.
- rsp0_rd / rsp1_rd  out  64  result.
- ise_valid  out  1  to co-processor cop_valid.
- ise_insn  out  32  to cop_insn.
- ise_rs1  out  64  to cop_rs1.
- ise_rs2  out  64  to cop_rs2.
- ise_rdywr  out  1  to cop_rdywr.
- ise_ready  in  1  from cop_ready.
- ise_wr  in  1  from cop_wr.
- ise_rd  in  64  from cop_rd.
- perf_stall  out  CNT_W  count of cycles with IR occupied but not retiring.

Behaviour:
- Reset values:
  - ir_v=0; rsp0_valid=rsp1_valid=0.
  - rspN_wr=0; rspN_rd=0.
  - rr_last=1, so requester 0 wins first.
  - perf_stall=0; ise_valid=0.
- Reset mid-operation drops the IR and both response buffers with no response produced. All state updates occur only on the rising cop_clk edge.
- The co-processor is combinational. ise_valid, ise_insn, ise_rs1 and ise_rs2 come directly from the IR registers.
- Slot availability: slot_free[x] = ~rsp_v[x] | rspx_ready.
- Retire condition: retire = ir_v & ise_ready & slot_free[ir_owner].
- ise_rdywr = slot_free[ir_owner], combinationally.
  - A recognised instruction with a full slot causes the co-processor to deassert cop_ready; the IR holds.
  - An unrecognised instruction (ise_wr=0) still waits for slot_free before retiring.
- ir_free = ~ir_v | retire.
- Request ready:
  - req0_ready = ir_free & (~req1_valid | rr_last==1).
  - req1_ready = ir_free & (~req0_valid | rr_last==0).
  - readyX never depends on reqX_valid.
- On acceptance of requester x:
  - The IR loads {x, insn, rs1, rs2} and sets ir_v=1.
  - rr_last is set to x.
  - If there is no acceptance and retire=1, ir_v is cleared.
- On retire:
  - rsp_v[owner] is set to 1; rsp_rd[owner] loads ise_rd; rsp_wr[owner] loads ise_wr.
  - A simultaneous pop and refill of the same slot leaves rsp_v=1 with the new data.
- Response pop: rsp_v[x] clears when rspx_valid & rspx_ready and there is no refill that cycle. rspN_rd and rspN_wr hold their values while valid.
- Latency:
  - A request accepted in cycle 0 presents to the co-processor in cycle 1, retires at the end of cycle 1, and shows rsp_valid in cycle 2.
  - Throughput is one op per cycle with alternating requesters and free slots.
- Single requester: back-to-back acceptance continues every cycle while its slot drains; round-robin only matters when both are valid.
- Ordering: responses per requester are in order, since there is one IR and one slot per requester.
- perf_stall increments each cycle with ir_v & ~retire and saturates at all-ones; it does not wrap.

Decomposition:
- Shared package:
  - CUSTOM_0..3 opcode constants.
  - Requester-id constants REQ0/REQ1.
  - Co-processor data width (64) and instruction width (32).
- Sub-module: cop_rr_arb2. Contains the 2-way round-robin grant with an rr_last register; inputs are the two valids and an advance strobe, outputs are the two grants.

Test Plan:
- Bench connects the ISE co-processor with ISE_V=2'b11.
- Single rori: req0 insn=0x8A00000B (rori imm=5), rs1=0x0000000000000001, accepted cycle 0 -> rsp0_valid in cycle 2 with rsp0_wr=1, rsp0_rd=0x0800000000000000; rsp1_valid stays 0.
- Unrecognised op: req1 insn=0x00000013 -> rsp1_valid in cycle 2 with rsp1_wr=0, rsp1_rd=0.
- Contention: req0 and req1 both valid continuously with free slots -> grants alternate 0,1,0,1 starting with 0 after reset; each rsp carries its own operands' rori result.
- Back-pressure: rsp0_ready=0 with rsp0 full, new req0 rori in IR -> ise_rdywr=0, ise_ready=0, IR held, perf_stall increments by 1 per cycle. Raising rsp0_ready retires in that cycle, and the new result is visible the next cycle with rsp0_valid held at 1.
- Saturation and reset: hold the stall 70000 cycles with CNT_W=16 -> perf_stall=0xFFFF and stays there. Assert cop_rst for one cycle mid-stall -> next cycle ir_v=0, rsp0_valid=0, perf_stall=0, and no response is emitted.
